// File: rtl/memchk_pkg.sv
// memchk_pkg: shared types for the data-memory write checker.
//   state_t  - checker FSM states (IDLE, CHECK, PASS, FAIL)
//   FC_*     - fail_code encodings reported on mem_write_checker.fail_code
package memchk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_OVERRUN  = 2'd3;

endpackage

// File: rtl/memchk_table.sv
// memchk_table: DEPTH-entry expected-write table {last, addr, data}.
//   clk           - write clock
//   i_we/i_widx   - write strobe and entry index
//   i_last/i_addr/i_data - entry contents to store
//   i_ridx        - combinational read index
//   o_last/o_addr/o_data - entry at i_ridx
// Contents are deliberately not reset so a table survives a checker reset.
module memchk_table #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_widx,
  input  logic                     i_last,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic [DATA_W-1:0]        i_data,
  input  logic [$clog2(DEPTH)-1:0] i_ridx,
  output logic                     o_last,
  output logic [ADDR_W-1:0]        o_addr,
  output logic [DATA_W-1:0]        o_data
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic              r_last [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_addr[i_widx] <= i_addr;
      r_data[i_widx] <= i_data;
      r_last[i_widx] <= i_last;
    end
  end

  assign o_addr = r_addr[i_ridx];
  assign o_data = r_data[i_ridx];
  assign o_last = r_last[i_ridx];

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: compares each data-memory store against an ordered table
// of expected (address, data) pairs and latches a pass/fail verdict.
//   clk, reset (sync, active-high)
//   exp_we/exp_idx/exp_addr/exp_data/exp_last - table load port (IDLE only)
//   start                                      - arm the checker (IDLE only)
//   mem_write/data_addr/write_data             - store port being monitored
//   done, pass, fail_code, fail_idx, fail_addr, fail_data - sticky verdict
//   writes_seen                                - stores matched so far
// Build option: define MEMCHK_TIMEOUT_EN to compile in the TIMEOUT watchdog
// (fail_code 2); without it CHECK waits indefinitely.
module mem_write_checker
  import memchk_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     exp_we,
  input  logic [$clog2(DEPTH)-1:0] exp_idx,
  input  logic [ADDR_W-1:0]        exp_addr,
  input  logic [DATA_W-1:0]        exp_data,
  input  logic                     exp_last,
  input  logic                     start,
  input  logic                     mem_write,
  input  logic [ADDR_W-1:0]        data_addr,
  input  logic [DATA_W-1:0]        write_data,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               fail_code,
  output logic [$clog2(DEPTH)-1:0] fail_idx,
  output logic [ADDR_W-1:0]        fail_addr,
  output logic [DATA_W-1:0]        fail_data,
  output logic [$clog2(DEPTH):0]   writes_seen
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [IW-1:0] PTR_MAX = IW'(DEPTH - 1);

  state_t            r_state, w_state_nxt;
  logic [IW-1:0]     r_ptr, w_ptr_nxt;
  logic [IW:0]       r_seen, w_seen_nxt;
  logic [1:0]        r_fc, w_fc_nxt;
  logic [IW-1:0]     r_fidx, w_fidx_nxt;
  logic [ADDR_W-1:0] r_faddr, w_faddr_nxt;
  logic [DATA_W-1:0] r_fdata, w_fdata_nxt;

  logic              w_ent_last;
  logic [ADDR_W-1:0] w_ent_addr;
  logic [DATA_W-1:0] w_ent_data;
  logic              w_match;
  logic              w_expire;

  memchk_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_table (
    .clk    (clk),
    .i_we   (exp_we && (r_state == IDLE)),
    .i_widx (exp_idx),
    .i_last (exp_last),
    .i_addr (exp_addr),
    .i_data (exp_data),
    .i_ridx (r_ptr),
    .o_last (w_ent_last),
    .o_addr (w_ent_addr),
    .o_data (w_ent_data)
  );

  // X/Z on the store port evaluates to X here, which falls into the
  // mismatch branch below rather than being treated as a match.
  assign w_match = (data_addr == w_ent_addr) && (write_data == w_ent_data);

`ifdef MEMCHK_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_timer;

  // Held at zero outside CHECK, so it starts counting the cycle after start.
  always_ff @(posedge clk) begin
    if (reset || (r_state != CHECK)) r_timer <= '0;
    else                             r_timer <= r_timer + 1'b1;
  end

  assign w_expire = (r_state == CHECK) && (r_timer == TW'(TIMEOUT - 1));
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_seen_nxt  = r_seen;
    w_fc_nxt    = r_fc;
    w_fidx_nxt  = r_fidx;
    w_faddr_nxt = r_faddr;
    w_fdata_nxt = r_fdata;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CHECK;
          w_ptr_nxt   = '0;
          w_seen_nxt  = '0;
        end
      end
      CHECK: begin
        if (mem_write && w_match) begin
          // A terminal match wins over a coincident timeout.
          if (w_ent_last) begin
            w_state_nxt = PASS;
            w_seen_nxt  = r_seen + 1'b1;
          end else if (r_ptr == PTR_MAX) begin
            w_state_nxt = FAIL;
            w_seen_nxt  = r_seen + 1'b1;
            w_fc_nxt    = FC_OVERRUN;
            w_fidx_nxt  = r_ptr;
            w_faddr_nxt = data_addr;
            w_fdata_nxt = write_data;
          end else if (w_expire) begin
            w_state_nxt = FAIL;
            w_fc_nxt    = FC_TIMEOUT;
            w_fidx_nxt  = r_ptr;
            w_faddr_nxt = '0;
            w_fdata_nxt = '0;
          end else begin
            w_ptr_nxt  = r_ptr + 1'b1;
            w_seen_nxt = r_seen + 1'b1;
          end
        end else if (mem_write) begin
          w_state_nxt = FAIL;
          w_fc_nxt    = FC_MISMATCH;
          w_fidx_nxt  = r_ptr;
          w_faddr_nxt = data_addr;
          w_fdata_nxt = write_data;
        end else if (w_expire) begin
          w_state_nxt = FAIL;
          w_fc_nxt    = FC_TIMEOUT;
          w_fidx_nxt  = r_ptr;
          w_faddr_nxt = '0;
          w_fdata_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_seen  <= '0;
      r_fc    <= FC_NONE;
      r_fidx  <= '0;
      r_faddr <= '0;
      r_fdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_seen  <= w_seen_nxt;
      r_fc    <= w_fc_nxt;
      r_fidx  <= w_fidx_nxt;
      r_faddr <= w_faddr_nxt;
      r_fdata <= w_fdata_nxt;
    end
  end

  assign done        = (r_state == PASS) || (r_state == FAIL);
  assign pass        = (r_state == PASS);
  assign fail_code   = r_fc;
  assign fail_idx    = r_fidx;
  assign fail_addr   = r_faddr;
  assign fail_data   = r_fdata;
  assign writes_seen = r_seen;

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: DEPTH=8, TIMEOUT=50
  logic        reset, exp_we, exp_last, start, mem_write;
  logic [2:0]  exp_idx;
  logic [31:0] exp_addr, exp_data, data_addr, write_data;
  logic        done, pass;
  logic [1:0]  fail_code;
  logic [2:0]  fail_idx;
  logic [31:0] fail_addr, fail_data;
  logic [3:0]  writes_seen;

  mem_write_checker #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (8),
    .TIMEOUT (50)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .exp_we      (exp_we),
    .exp_idx     (exp_idx),
    .exp_addr    (exp_addr),
    .exp_data    (exp_data),
    .exp_last    (exp_last),
    .start       (start),
    .mem_write   (mem_write),
    .data_addr   (data_addr),
    .write_data  (write_data),
    .done        (done),
    .pass        (pass),
    .fail_code   (fail_code),
    .fail_idx    (fail_idx),
    .fail_addr   (fail_addr),
    .fail_data   (fail_data),
    .writes_seen (writes_seen)
  );

  // Second DUT: DEPTH=2 for the table-overrun case
  logic        d2_reset, d2_exp_we, d2_exp_last, d2_start, d2_mem_write;
  logic [0:0]  d2_exp_idx;
  logic [31:0] d2_exp_addr, d2_exp_data, d2_data_addr, d2_write_data;
  logic        d2_done, d2_pass;
  logic [1:0]  d2_fail_code;
  logic [0:0]  d2_fail_idx;
  logic [31:0] d2_fail_addr, d2_fail_data;
  logic [1:0]  d2_writes_seen;

  mem_write_checker #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .DEPTH   (2),
    .TIMEOUT (50)
  ) u_dut2 (
    .clk         (clk),
    .reset       (d2_reset),
    .exp_we      (d2_exp_we),
    .exp_idx     (d2_exp_idx),
    .exp_addr    (d2_exp_addr),
    .exp_data    (d2_exp_data),
    .exp_last    (d2_exp_last),
    .start       (d2_start),
    .mem_write   (d2_mem_write),
    .data_addr   (d2_data_addr),
    .write_data  (d2_write_data),
    .done        (d2_done),
    .pass        (d2_pass),
    .fail_code   (d2_fail_code),
    .fail_idx    (d2_fail_idx),
    .fail_addr   (d2_fail_addr),
    .fail_data   (d2_fail_data),
    .writes_seen (d2_writes_seen)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  typedef struct {
    logic        rst;
    logic        st;
    logic        mw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        e_done;
    logic        e_pass;
    logic [1:0]  e_fc;
    logic [3:0]  e_seen;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic st, input logic mw,
                       input logic [31:0] a, input logic [31:0] d);
    reset = rst; start = st; mem_write = mw; data_addr = a; write_data = d;
  endtask

  task automatic load(input logic [2:0] idx, input logic [31:0] a,
                      input logic [31:0] d, input logic l);
    exp_we = 1'b1; exp_idx = idx; exp_addr = a; exp_data = d; exp_last = l;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic chk_status(input string nm, input logic e_done, input logic e_pass,
                            input logic [1:0] e_fc, input logic [3:0] e_seen);
    chk({nm, " done"}, 64'(done), 64'(e_done));
    chk({nm, " pass"}, 64'(pass), 64'(e_pass));
    chk({nm, " fail_code"}, 64'(fail_code), 64'(e_fc));
    chk({nm, " writes_seen"}, 64'(writes_seen), 64'(e_seen));
  endtask

  task automatic chk_all_zero(input string nm);
    chk_status(nm, 1'b0, 1'b0, 2'd0, 4'd0);
    chk({nm, " fail_idx"}, 64'(fail_idx), 64'd0);
    chk({nm, " fail_addr"}, 64'(fail_addr), 64'd0);
    chk({nm, " fail_data"}, 64'(fail_data), 64'd0);
  endtask

  initial begin
    //           rst   st    mw    addr   data  done  pass  fc  seen
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'h80, 32'd7, 1'b0, 1'b0, 2'd0, 4'd0}; // store before start ignored
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 2'd0, 4'd0}; // arm
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 32'h80, 32'd7, 1'b0, 1'b0, 2'd0, 4'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 2'd0, 4'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h84, 32'd7, 1'b1, 1'b1, 2'd0, 4'd2}; // terminal match
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h84, 32'd6, 1'b1, 1'b1, 2'd0, 4'd2}; // ignored in PASS
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'd0, 1'b1, 1'b1, 2'd0, 4'd2}; // start ignored in PASS
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 2'd0, 4'd0}; // reset
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h0,  32'd0, 1'b0, 1'b0, 2'd0, 4'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h80, 32'd7, 1'b0, 1'b0, 2'd0, 4'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h84, 32'd6, 1'b1, 1'b0, 2'd1, 4'd1}; // back-to-back mismatch
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h80, 32'd7, 1'b1, 1'b0, 2'd1, 4'd1}; // ignored in FAIL

    exp_we = 1'b0; exp_idx = '0; exp_addr = '0; exp_data = '0; exp_last = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    d2_reset = 1'b1; d2_exp_we = 1'b0; d2_exp_idx = '0; d2_exp_addr = '0;
    d2_exp_data = '0; d2_exp_last = 1'b0; d2_start = 1'b0; d2_mem_write = 1'b0;
    d2_data_addr = '0; d2_write_data = '0;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    d2_reset = 1'b0;

    load(3'd0, 32'h80, 32'd7, 1'b0);
    load(3'd1, 32'h84, 32'd7, 1'b1);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].mw, vecs[i].addr, vecs[i].data);
      tick();
      chk_status($sformatf("vec%0d", i), vecs[i].e_done, vecs[i].e_pass,
                 vecs[i].e_fc, vecs[i].e_seen);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("mismatch fail_idx", 64'(fail_idx), 64'd1);
    chk("mismatch fail_addr", 64'(fail_addr), 64'h84);
    chk("mismatch fail_data", 64'(fail_data), 64'd6);

    // Reset clears a captured failure
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all_zero("reset after fail");

    // exp_we during CHECK must not alter the table
    start = 1'b1; tick(); start = 1'b0;
    load(3'd0, 32'h90, 32'd1, 1'b1);
    load(3'd1, 32'h84, 32'h55, 1'b0);
    chk_status("we in check", 1'b0, 1'b0, 2'd0, 4'd0);
    drive(1'b0, 1'b0, 1'b1, 32'h80, 32'd7); tick();
    drive(1'b0, 1'b0, 1'b1, 32'h84, 32'd7); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_status("table kept", 1'b1, 1'b1, 2'd0, 4'd2);

    // Reset mid-CHECK after one match, then rerun
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h80, 32'd7); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_status("mid check", 1'b0, 1'b0, 2'd0, 4'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk_all_zero("mid reset");
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h80, 32'd7); tick();
    drive(1'b0, 1'b0, 1'b1, 32'h84, 32'd7); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_status("rerun", 1'b1, 1'b1, 2'd0, 4'd2);

    // Watchdog: start sampled at edge 0, deciding edge is edge 50
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h80, 32'd7); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 48; c++) tick();
    chk_status("to edge49", 1'b0, 1'b0, 2'd0, 4'd1);
    tick();
`ifdef MEMCHK_TIMEOUT_EN
    chk_status("timeout", 1'b1, 1'b0, 2'd2, 4'd1);
    chk("timeout fail_idx", 64'(fail_idx), 64'd1);
    chk("timeout fail_addr", 64'(fail_addr), 64'd0);
    chk("timeout fail_data", 64'(fail_data), 64'd0);
    // Terminal store on the expiry edge wins
    reset = 1'b1; tick(); reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h80, 32'd7); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 48; c++) tick();
    drive(1'b0, 1'b0, 1'b1, 32'h84, 32'd7); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_status("expiry race", 1'b1, 1'b1, 2'd0, 4'd2);
`else
    chk_status("no timeout", 1'b0, 1'b0, 2'd0, 4'd1);
    for (int c = 0; c < 20; c++) tick();
    drive(1'b0, 1'b0, 1'b1, 32'h84, 32'd7); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_status("late pass", 1'b1, 1'b1, 2'd0, 4'd2);
`endif

    // DEPTH=2 overrun: both entries match, neither is last
    d2_exp_we = 1'b1; d2_exp_idx = 1'b0; d2_exp_addr = 32'h80; d2_exp_data = 32'd7;
    d2_exp_last = 1'b0; tick();
    d2_exp_idx = 1'b1; d2_exp_addr = 32'h84; tick();
    d2_exp_we = 1'b0;
    d2_start = 1'b1; tick(); d2_start = 1'b0;
    d2_mem_write = 1'b1; d2_data_addr = 32'h80; d2_write_data = 32'd7; tick();
    chk("ovr first done", 64'(d2_done), 64'd0);
    d2_data_addr = 32'h84; tick();
    d2_mem_write = 1'b0;
    chk("ovr done", 64'(d2_done), 64'd1);
    chk("ovr pass", 64'(d2_pass), 64'd0);
    chk("ovr fail_code", 64'(d2_fail_code), 64'd3);
    chk("ovr fail_idx", 64'(d2_fail_idx), 64'd1);
    chk("ovr fail_addr", 64'(d2_fail_addr), 64'h84);
    chk("ovr writes_seen", 64'(d2_writes_seen), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
